// File: rtl/avst_pkt_buffer_pkg.sv
// Shared types for the store-and-forward Avalon-ST packet buffer.
// The FSM state encoding lives here so the top and any checkers agree on it.
package avst_pkt_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2,
        ST_SEND = 2'd3
    } pkt_state_e;

endpackage

// File: rtl/avst_if.sv
// Avalon-ST signal bundle (data, sop, eop, valid, ready) for one stream direction.
interface avst_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;
endinterface

// File: rtl/avst_pkt_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; only words inside the current packet are ever read.
module avst_pkt_mem #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_r [DEPTH];

    // Write port: one word per enabled clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/avst_pkt_buffer.sv
// Store-and-forward Avalon-ST packet buffer: captures one whole packet (truncating at
// MAX_PKT_LEN), then replays it gap-free once its endofpacket has been stored.
module avst_pkt_buffer
    import avst_pkt_buffer_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16,
    parameter int AWIDTH      = $clog2(MAX_PKT_LEN)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DWIDTH-1:0] snk_data,
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DWIDTH-1:0] src_data,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              trunc_o
);

    localparam logic [AWIDTH-1:0] ZERO_ADDR = {AWIDTH{1'b0}};
    localparam logic [AWIDTH-1:0] ONE_ADDR  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MAX_PKT_LEN - 1);
    localparam logic [AWIDTH:0]   ONE_LEN   = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]   MAX_LEN   = (AWIDTH + 1)'(MAX_PKT_LEN);

    pkt_state_e        state_r;
    pkt_state_e        state_nxt_s;
    logic [AWIDTH-1:0] wr_cnt_r;
    logic [AWIDTH-1:0] wr_cnt_nxt_s;
    logic [AWIDTH-1:0] rd_cnt_r;
    logic [AWIDTH-1:0] rd_cnt_nxt_s;
    logic [AWIDTH:0]   len_r;
    logic [AWIDTH:0]   len_nxt_s;
    logic              trunc_r;
    logic              trunc_nxt_s;
    logic              rdy_en_r;
    logic              we_s;
    logic [AWIDTH-1:0] waddr_s;
    logic [DWIDTH-1:0] mem_rdata_s;
    logic              snk_fire_s;
    logic              src_fire_s;
    logic              send_s;
    logic              last_word_s;

    avst_pkt_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (snk_data),
        .raddr (rd_cnt_r),
        .rdata (mem_rdata_s)
    );

    // rdy_en_r keeps the sink closed while reset is held and for no longer.
    assign send_s      = (state_r == ST_SEND);
    assign snk_ready   = rdy_en_r && !send_s;
    assign snk_fire_s  = snk_valid && snk_ready;
    assign src_fire_s  = send_s && src_ready;
    assign last_word_s = ({1'b0, rd_cnt_r} == (len_r - ONE_LEN));

    assign src_valid         = send_s;
    assign src_data          = send_s ? mem_rdata_s : {DWIDTH{1'b0}};
    assign src_startofpacket = send_s && (rd_cnt_r == ZERO_ADDR);
    assign src_endofpacket   = send_s && last_word_s;
    assign trunc_o           = trunc_r;

    // Next-state, counter and memory-write decode.
    always_comb begin
        state_nxt_s  = state_r;
        wr_cnt_nxt_s = wr_cnt_r;
        rd_cnt_nxt_s = rd_cnt_r;
        len_nxt_s    = len_r;
        trunc_nxt_s  = 1'b0;
        we_s         = 1'b0;
        waddr_s      = wr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (snk_fire_s && snk_startofpacket) begin
                    we_s    = 1'b1;
                    waddr_s = ZERO_ADDR;
                    if (snk_endofpacket) begin
                        len_nxt_s    = ONE_LEN;
                        wr_cnt_nxt_s = ZERO_ADDR;
                        state_nxt_s  = ST_SEND;
                    end else begin
                        wr_cnt_nxt_s = ONE_ADDR;
                        state_nxt_s  = ST_RECV;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (snk_fire_s) begin
                    we_s = 1'b1;
                    if (snk_startofpacket) begin
                        // A fresh sop abandons the partial packet and restarts at address 0.
                        waddr_s = ZERO_ADDR;
                        if (snk_endofpacket) begin
                            len_nxt_s    = ONE_LEN;
                            wr_cnt_nxt_s = ZERO_ADDR;
                            state_nxt_s  = ST_SEND;
                        end else begin
                            wr_cnt_nxt_s = ONE_ADDR;
                            state_nxt_s  = ST_RECV;
                        end
                    end else if (snk_endofpacket) begin
                        len_nxt_s    = {1'b0, wr_cnt_r} + ONE_LEN;
                        wr_cnt_nxt_s = ZERO_ADDR;
                        state_nxt_s  = ST_SEND;
                    end else if (wr_cnt_r == LAST_ADDR) begin
                        len_nxt_s    = MAX_LEN;
                        trunc_nxt_s  = 1'b1;
                        wr_cnt_nxt_s = ZERO_ADDR;
                        state_nxt_s  = ST_DROP;
                    end else begin
                        wr_cnt_nxt_s = wr_cnt_r + ONE_ADDR;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DROP: begin
                if (snk_fire_s && snk_endofpacket) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_SEND: begin
                if (src_fire_s) begin
                    if (last_word_s) begin
                        rd_cnt_nxt_s = ZERO_ADDR;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        rd_cnt_nxt_s = rd_cnt_r + ONE_ADDR;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                wr_cnt_nxt_s = ZERO_ADDR;
                rd_cnt_nxt_s = ZERO_ADDR;
            end
        endcase
    end

    // State, counters and truncation pulse register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_r  <= ST_IDLE;
            wr_cnt_r <= ZERO_ADDR;
            rd_cnt_r <= ZERO_ADDR;
            len_r    <= {(AWIDTH + 1){1'b0}};
            trunc_r  <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
            rd_cnt_r <= rd_cnt_nxt_s;
            len_r    <= len_nxt_s;
            trunc_r  <= trunc_nxt_s;
            rdy_en_r <= 1'b1;
        end
    end

endmodule
